// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the microprogrammed CPU control path.
//   - CAR sequencing-field command codes (bits of the microword that tell
//     the control address register what to do next).
//   - Run-controller state encoding. The values are fixed because the
//     encoding is visible to debug tooling.
//   - is_boundary(): an instruction boundary is a microword that asks the
//     CAR to fetch the next instruction.
package cpu_ctrl_pkg;

   localparam logic [1:0] CAR_NOP   = 2'b00;
   localparam logic [1:0] CAR_JUMP  = 2'b01;
   localparam logic [1:0] CAR_INC   = 2'b10;
   localparam logic [1:0] CAR_FETCH = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_STEP_WAIT = 3'd2,
      ST_RESUME    = 3'd3,
      ST_HALTED    = 3'd4
   } run_state_e;

   function automatic logic is_boundary(input logic [1:0] car);
      return car == CAR_FETCH;
   endfunction

endpackage

// File: rtl/run_ctrl_edge_det.sv
// run_ctrl_edge_det
//   Rising-edge detector for a synchronous, already-debounced level input.
//   The history bit is registered; pulse is high in the cycle where level
//   is 1 and was 0 at the previous clock edge, so a held level yields a
//   single pulse.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (clears history)
//   level in   level input
//   pulse out  one-cycle rising-edge indication
module run_ctrl_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk) begin
      if (rst) level_q <= 1'b0;
      else     level_q <= level;
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Run-control sequencer for the microprogrammed CPU. Finds instruction
//   boundaries from the CAR sequencing field, handles auto/step execution,
//   HALT and abort, and counts retired instructions and RUN cycles
//   (both saturating).
//   Optional feature macro: CPU_BREAKPOINT_EN adds a PC breakpoint that
//   pauses (STEP_WAIT) before the instruction at i_bp_addr executes.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start_req               run request (0->1 edge used)
//   i_step_mode               single-instruction mode, sampled on start
//   i_next_req                next-instruction request (0->1 edge used)
//   i_stop_req                abort, acts in every state
//   i_control_word_car        CAR sequencing field of current microword
//   i_ctrl_halt               halt bit of current microword
//   i_pc                      current PC (breakpoint compare only)
//   i_bp_addr, i_bp_valid     breakpoint address/enable (macro only)
//   o_bp_hit                  paused on a breakpoint (macro only)
//   o_cpu_start               CPU enabled
//   o_step_execution          latched step mode
//   o_next_instr_stimulus     one-cycle release pulse to the CAR
//   o_halted                  HALT executed
//   o_instr_count             retired instructions
//   o_cycle_count             cycles spent in RUN
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int PC_W  = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start_req,
   input  logic             i_step_mode,
   input  logic             i_next_req,
   input  logic             i_stop_req,
   input  logic [1:0]       i_control_word_car,
   input  logic             i_ctrl_halt,
   input  logic [PC_W-1:0]  i_pc,
`ifdef CPU_BREAKPOINT_EN
   input  logic [PC_W-1:0]  i_bp_addr,
   input  logic             i_bp_valid,
   output logic             o_bp_hit,
`endif
   output logic             o_cpu_start,
   output logic             o_step_execution,
   output logic             o_next_instr_stimulus,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_instr_count,
   output logic [CNT_W-1:0] o_cycle_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   run_state_e state, state_nxt;
   logic       start_pulse, next_pulse;
   logic       boundary, bp_match;
   logic       retire, bp_entry;

   run_ctrl_edge_det u_start_edge (
      .clk   (i_clk),
      .rst   (i_rst),
      .level (i_start_req),
      .pulse (start_pulse)
   );

   run_ctrl_edge_det u_next_edge (
      .clk   (i_clk),
      .rst   (i_rst),
      .level (i_next_req),
      .pulse (next_pulse)
   );

   assign boundary = is_boundary(i_control_word_car);

`ifdef CPU_BREAKPOINT_EN
   assign bp_match = i_bp_valid && (i_pc == i_bp_addr);
`else
   logic unused_pc;
   assign unused_pc = ^i_pc;
   assign bp_match  = 1'b0;
`endif

   // Next state plus the retire strobe. Stop overrides everything; retire
   // stays 0 under stop so counters hold.
   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      bp_entry  = 1'b0;
      if (i_stop_req) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:      if (start_pulse) state_nxt = ST_RUN;
            ST_RUN: begin
               if (boundary) begin
                  if (i_ctrl_halt) begin
                     state_nxt = ST_HALTED;
                     retire    = 1'b1;
                  end else if (bp_match) begin
                     state_nxt = ST_STEP_WAIT;
                     bp_entry  = 1'b1;
                  end else if (o_step_execution) begin
                     state_nxt = ST_STEP_WAIT;
                  end else begin
                     retire    = 1'b1;
                  end
               end
            end
            ST_STEP_WAIT: if (next_pulse) state_nxt = ST_RESUME;
            // RESUME ignores the CAR field: the boundary microword is still
            // present and must not re-enter STEP_WAIT before the release.
            ST_RESUME: begin
               state_nxt = ST_RUN;
               retire    = 1'b1;
            end
            ST_HALTED:    state_nxt = ST_HALTED;
            default:      state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from next state and registered with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state                 <= ST_IDLE;
         o_cpu_start           <= 1'b0;
         o_step_execution      <= 1'b0;
         o_next_instr_stimulus <= 1'b0;
         o_halted              <= 1'b0;
         o_instr_count         <= '0;
         o_cycle_count         <= '0;
      end else begin
         state                 <= state_nxt;
         o_cpu_start           <= state_nxt != ST_IDLE;
         o_next_instr_stimulus <= state_nxt == ST_RESUME;
         o_halted              <= state_nxt == ST_HALTED;
         if (!i_stop_req && state == ST_IDLE && start_pulse) begin
            o_step_execution <= i_step_mode;
            o_instr_count    <= '0;
            o_cycle_count    <= '0;
         end else if (!i_stop_req) begin
            if (retire && o_instr_count != CNT_MAX)
               o_instr_count <= o_instr_count + CNT_W'(1);
            if (state == ST_RUN && o_cycle_count != CNT_MAX)
               o_cycle_count <= o_cycle_count + CNT_W'(1);
         end
      end
   end

`ifdef CPU_BREAKPOINT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)                                     o_bp_hit <= 1'b0;
      else if (i_stop_req || state == ST_RESUME)     o_bp_hit <= 1'b0;
      else if (bp_entry)                             o_bp_hit <= 1'b1;
   end
`else
   logic unused_bp;
   assign unused_bp = bp_entry;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller. A reference model computes the expected
// outputs for every clock edge and queues them; a monitor on the falling
// edge pops and compares. Directed phases follow the run-control scenarios,
// then a randomized phase exercises mixed traffic.
module tb_cpu_run_controller;

   localparam int CNT_W = 4;
   localparam int PC_W  = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst, start_req, step_mode, next_req, stop_req, halt;
   logic [1:0]       car;
   logic [PC_W-1:0]  pc;
   logic             cpu_start, step_exec, stim, halted;
   logic [CNT_W-1:0] ic, cc;
`ifdef CPU_BREAKPOINT_EN
   logic [PC_W-1:0]  bp_addr;
   logic             bp_valid, bp_hit;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   cpu_run_controller #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
      .i_clk                 (clk),
      .i_rst                 (rst),
      .i_start_req           (start_req),
      .i_step_mode           (step_mode),
      .i_next_req            (next_req),
      .i_stop_req            (stop_req),
      .i_control_word_car    (car),
      .i_ctrl_halt           (halt),
      .i_pc                  (pc),
`ifdef CPU_BREAKPOINT_EN
      .i_bp_addr             (bp_addr),
      .i_bp_valid            (bp_valid),
      .o_bp_hit              (bp_hit),
`endif
      .o_cpu_start           (cpu_start),
      .o_step_execution      (step_exec),
      .o_next_instr_stimulus (stim),
      .o_halted              (halted),
      .o_instr_count         (ic),
      .o_cycle_count         (cc)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_OFF, M_GO, M_PAUSE, M_PULSE, M_DONE} mmode_e;
   typedef struct {
      int start; int step; int stim; int halted; int ic; int cc; int bp;
   } exp_t;

   exp_t   sbq[$];
   mmode_e m_mode = M_OFF;
   int     m_step = 0, m_ic = 0, m_cc = 0, m_bp = 0;
   bit     m_sprev = 0, m_nprev = 0;

   function automatic int sat(input int v);
      return (v >= CMAX) ? v : v + 1;
   endfunction

   always @(posedge clk) begin : model
      bit   se, ne, bnd, bpm;
      exp_t e;
      se  = start_req && !m_sprev;
      ne  = next_req && !m_nprev;
      m_sprev = start_req;
      m_nprev = next_req;
      bnd = (car == 2'b11);
`ifdef CPU_BREAKPOINT_EN
      bpm = bp_valid && (pc == bp_addr);
`else
      bpm = 1'b0;
`endif
      if (rst) begin
         m_sprev = 0; m_nprev = 0;
         m_mode = M_OFF; m_step = 0; m_ic = 0; m_cc = 0; m_bp = 0;
      end else if (stop_req) begin
         m_mode = M_OFF; m_bp = 0;
      end else begin
         case (m_mode)
            M_OFF: if (se) begin
               m_mode = M_GO; m_step = int'(step_mode); m_ic = 0; m_cc = 0;
            end
            M_GO: begin
               m_cc = sat(m_cc);
               if (bnd && halt)        begin m_mode = M_DONE; m_ic = sat(m_ic); end
               else if (bnd && bpm)    begin m_mode = M_PAUSE; m_bp = 1; end
               else if (bnd && m_step != 0) m_mode = M_PAUSE;
               else if (bnd)           m_ic = sat(m_ic);
            end
            M_PAUSE: if (ne) m_mode = M_PULSE;
            M_PULSE: begin m_mode = M_GO; m_ic = sat(m_ic); m_bp = 0; end
            default: ;
         endcase
      end
      e.start  = (m_mode != M_OFF) ? 1 : 0;
      e.step   = m_step;
      e.stim   = (m_mode == M_PULSE) ? 1 : 0;
      e.halted = (m_mode == M_DONE) ? 1 : 0;
      e.ic     = m_ic;
      e.cc     = m_cc;
      e.bp     = m_bp;
      sbq.push_back(e);
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         e = sbq.pop_front();
         check("cpu_start",   int'(cpu_start), e.start);
         check("step_exec",   int'(step_exec), e.step);
         check("stimulus",    int'(stim),      e.stim);
         check("halted",      int'(halted),    e.halted);
         check("instr_count", int'(ic),        e.ic);
         check("cycle_count", int'(cc),        e.cc);
`ifdef CPU_BREAKPOINT_EN
         check("bp_hit",      int'(bp_hit),    e.bp);
`endif
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; start_req = 0; step_mode = 0; next_req = 0; stop_req = 0;
      halt = 0; car = 2'b00; pc = '0;
`ifdef CPU_BREAKPOINT_EN
      bp_addr = 8'h05; bp_valid = 0;
`endif
      cyc(2);
      check("reset_cpu_start", int'(cpu_start), 0);
      check("reset_instr",     int'(ic), 0);
      rst = 0;
      cyc(1);

      // auto run: three instructions of car 10,10,11
      start_req = 1; step_mode = 0; cyc(1);
      start_req = 0;
      for (int i = 0; i < 3; i++) begin
         car = 2'b10; cyc(1);
         car = 2'b10; cyc(1);
         car = 2'b11; cyc(1);
      end
      car = 2'b00; stop_req = 1; cyc(1);
      check("auto_instr", int'(ic), 3);
      check("auto_cycle", int'(cc), 9);
      stop_req = 0; cyc(1);

      // step mode with held boundary
      start_req = 1; step_mode = 1; car = 2'b11; cyc(1);
      start_req = 0; cyc(20);
      check("step_wait_stim", int'(stim), 0);
      next_req = 1; cyc(1);
      check("step_pulse", int'(stim), 1);
      cyc(1);
      check("step_pulse_end", int'(stim), 0);
      check("step_instr", int'(ic), 1);
      cyc(8);
      check("held_next_one_pulse", int'(stim), 0);
      next_req = 0; stop_req = 1; cyc(1);
      stop_req = 0; cyc(1);

      // halt
      start_req = 1; step_mode = 0; car = 2'b11; halt = 1; cyc(1);
      start_req = 0; cyc(1);
      check("halt_flag", int'(halted), 1);
      check("halt_instr", int'(ic), 1);
      cyc(50);
      check("halt_held", int'(halted), 1);
      check("halt_cpu_start", int'(cpu_start), 1);
      stop_req = 1; cyc(1);
      check("halt_stop", int'(cpu_start), 0);
      stop_req = 0; halt = 0; car = 2'b00; cyc(1);

      // stop beats start
      start_req = 1; cyc(1);
      start_req = 0; cyc(1);
      start_req = 1; stop_req = 1; cyc(1);
      check("stop_wins_run", int'(cpu_start), 0);
      start_req = 0; stop_req = 0; cyc(1);
      start_req = 1; stop_req = 1; cyc(1);
      check("stop_wins_idle", int'(cpu_start), 0);
      start_req = 0; stop_req = 0; cyc(1);

      // saturation then reset mid-run
      start_req = 1; step_mode = 0; car = 2'b11; cyc(1);
      start_req = 0; cyc(20);
      check("sat_instr", int'(ic), 15);
      check("sat_cycle", int'(cc), 15);
      rst = 1; cyc(1);
      check("midrun_rst_start", int'(cpu_start), 0);
      check("midrun_rst_instr", int'(ic), 0);
      rst = 0; car = 2'b00; cyc(1);

`ifdef CPU_BREAKPOINT_EN
      bp_addr = 8'h05; bp_valid = 1;
      start_req = 1; step_mode = 0; car = 2'b11; pc = 8'h03; cyc(1);
      start_req = 0; pc = 8'h04; cyc(1);
      pc = 8'h05; cyc(1);
      check("bp_hit_set", int'(bp_hit), 1);
      next_req = 1; cyc(1);
      next_req = 0; pc = 8'h06; cyc(1);
      check("bp_hit_clear", int'(bp_hit), 0);
      stop_req = 1; cyc(1);
      stop_req = 0; car = 2'b00; cyc(1);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 299) == 0);
         stop_req  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 3) == 0) start_req = ~start_req;
         if ($urandom_range(0, 2) == 0) next_req  = ~next_req;
         step_mode = 1'($urandom);
         car       = 2'($urandom);
         halt      = ($urandom_range(0, 9) == 0);
         pc        = PC_W'($urandom_range(0, 7));
`ifdef CPU_BREAKPOINT_EN
         bp_valid  = ($urandom_range(0, 3) != 0);
`endif
         cyc(1);
      end

      rst = 0; stop_req = 0;
      cyc(2);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Run-control sequencer for the microprogrammed CPU. It produces the start, step-mode, next-instruction and halted signals that govern the control address register. It watches the CAR sequencing field and the halt bit to find instruction boundaries, and it counts retired instructions and active cycles. It sits between the host/board control inputs and the control unit.

## Interface
- `CNT_W`, default 16: width of the instruction and cycle counters.
- `PC_W`, default 8: width of the PC compared for breakpoints.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start_req`  in  1  run request. Level input; its 0→1 edge is used.
- `i_step_mode`  in  1  1 = single-instruction mode. Sampled on the start edge.
- `i_next_req`  in  1  next-instruction request. Level input; its 0→1 edge is used.
- `i_stop_req`  in  1  abort. Level input; acts in any state.
- `i_control_word_car`  in  2  CAR sequencing field of the current microword.
- `i_ctrl_halt`  in  1  halt bit of the current microword (C23).
- `i_pc`  in  PC_W  current PC. Used only with `CPU_BREAKPOINT_EN`.
- `o_cpu_start`  out  1  CPU enabled. CAR output is forced to 0 while this is low.
- `o_step_execution`  out  1  latched step mode.
- `o_next_instr_stimulus`  out  1  one-cycle release pulse to the CAR.
- `o_halted`  out  1  HALT instruction executed.
- `o_instr_count`  out  CNT_W  retired instructions, saturating.
- `o_cycle_count`  out  CNT_W  cycles spent in RUN, saturating.
- All inputs are synchronous to `i_clk`; debounce is done upstream.

## Operation
- States: IDLE, RUN, STEP_WAIT, RESUME, HALTED.
- Boundary: `i_control_word_car == 2'b11`.
- IDLE → RUN on the start edge.
  - Latch `i_step_mode` into `o_step_execution`.
  - Clear both counters.
  - Start edges in any other state are ignored.
- In RUN, at a boundary, by priority:
  1. `i_ctrl_halt` = 1 → HALTED.
  2. Breakpoint hit (macro only) → STEP_WAIT.
  3. Step mode → STEP_WAIT.
  4. Otherwise stay in RUN; the CAR auto-fetches.
- STEP_WAIT → RESUME on the next edge.
- RESUME: `o_next_instr_stimulus` = 1; → RUN unconditionally.
  - RESUME prevents the still-present `2'b11` from re-triggering STEP_WAIT.
- HALTED: `o_halted` = 1 and `o_cpu_start` stays 1 (CAR holds). Only stop leaves this state.
- A stop in any state has top priority: → IDLE and `o_cpu_start` = 0. Counters hold their values.
- Retire event, adds 1 to `o_instr_count`:
  - RUN, boundary, no halt, not step, no breakpoint; or
  - entry to HALTED; or
  - a cycle in RESUME.
- `o_cycle_count` adds 1 for each cycle in RUN.
- Both counters saturate at all-ones and do not wrap.
- Outputs are registered Moore decodes of the state:
  - `o_cpu_start` = state ≠ IDLE.
  - `o_next_instr_stimulus` = state == RESUME.
  - `o_halted` = state == HALTED.

## Timing
- Reset (synchronous, one edge):
  - state IDLE, all outputs 0, counters 0, edge-detect history 0.
- Reset mid-run is handled identically; there is no partial state.
- Start edge sampled at edge t → `o_cpu_start` = 1 from t+1.
- Boundary in step mode sampled at t → STEP_WAIT from t+1.
- Next edge sampled at t' → stimulus high for exactly cycle t'+1 → RUN at t'+2.
- A next edge outside STEP_WAIT is discarded, not queued.
- Stop and start asserted in the same cycle: stop wins.
- A held `i_next_req` gives one pulse only.

## Configuration
- `CPU_BREAKPOINT_EN` defined:
  - Adds input `i_bp_addr` [PC_W] and input `i_bp_valid`.
  - Adds output `o_bp_hit`, set on a breakpoint entry to STEP_WAIT and cleared in RESUME.
  - Breakpoint hit = RUN, boundary, no halt, `i_bp_valid`, `i_pc == i_bp_addr`.
  - Effect: pause before the instruction at that address executes, in either mode.
- Not defined: these ports and the logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - CAR command constants: CAR_NOP = 00, CAR_JUMP = 01, CAR_INC = 10, CAR_FETCH = 11.
  - Run-state enum with fixed encoding: IDLE = 0, RUN = 1, STEP_WAIT = 2, RESUME = 3, HALTED = 4.
- Sub-module `run_ctrl_edge_det` (registered rising-edge pulse), instantiated for start and next.

## Test plan
- Auto run: start edge, step = 0; drive car = 10, 10, 11 three times → instr_count = 3, cycle_count = 9, stimulus never asserted.
- Step: start with step = 1; car held at 11 → STEP_WAIT, stimulus 0 for 20 cycles; one next pulse → stimulus high exactly one cycle, instr_count = 1.
- Halt: car = 11 with halt = 1 → `o_halted` = 1, instr_count increments once, state held for 50 cycles; stop → IDLE, `o_cpu_start` = 0.
- Priority: stop and start in the same cycle from RUN → IDLE. A held next for 10 cycles → exactly one pulse.
- Saturation: CNT_W = 4; 20 auto boundaries → instr_count = 15. Synchronous reset mid-RUN → all outputs 0 on the next edge.
- Breakpoint (macro): bp_addr = 0x05, valid, auto mode; PC reaches 0x05 at a boundary → STEP_WAIT, `o_bp_hit` = 1; next pulse → RUN, `o_bp_hit` = 0.
